// File: rtl/instr_seq.sv
// MSP430 instruction sequencer: Moore FSM stepping each instruction through fetch,
// extension-word fetch, operand read, execute and write-back. Optional perf counters: MSP430_SEQ_PERF_EN.
module instr_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] MDB_out,
    input  logic        mem_ready,
    input  logic        cond_true,
    output logic [15:0] IR,
    output logic [15:0] EXT_SRC,
    output logic [15:0] EXT_DST,
    output logic [2:0]  MAB_sel,
    output logic [2:0]  MPC,
    output logic        SA_inc,
    output logic        exec,
    output logic        RW,
    output logic        MW,
    output logic        instr_done,
    output logic        illegal,
    output logic        busy,
    output logic [15:0] instr_count,
    output logic [15:0] stall_count
);

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEXT  = 3'd2,
        ST_DEXT  = 3'd3,
        ST_SRD   = 3'd4,
        ST_DRD   = 3'd5,
        ST_EXEC  = 3'd6,
        ST_WB    = 3'd7
    } state_t;

    typedef struct packed {
        logic jump;
        logic illegal;
        logic sext;
        logic dext;
        logic srd;
        logic drd;
        logic wb;
        logic rw;
        logic sa_inc;
        logic indirect;
    } dec_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] ext_src_q, ext_src_d;
    logic [15:0] ext_dst_q, ext_dst_d;
    dec_t        dec_s;
    logic        mem_state_s;

    function automatic dec_t decode(input logic [15:0] w);
        dec_t       d;
        logic [3:0] op;
        logic [3:0] src;
        logic [1:0] as_f;
        logic       ad;
        logic       fmt1;
        logic       fmt2;
        logic       cg;
        logic       imm;
        logic       single_wr;
        d         = '0;
        op        = w[15:12];
        as_f      = w[5:4];
        ad        = w[7];
        d.jump    = (w[15:13] == 3'b001);
        fmt2      = (op == 4'b0001);
        fmt1      = (op >= 4'b0100);
        d.illegal = !(d.jump || fmt1 || fmt2);
        src       = fmt2 ? w[3:0] : w[11:8];
        cg        = (src == 4'd3) || ((src == 4'd2) && as_f[1]);
        imm       = (as_f == 2'b11) && (src == 4'd0);
        // RRC/SWPB/RRA/SXT are the single-operand ops that write their operand back
        single_wr = fmt2 && (w[9] == 1'b0);
        if (fmt1 || fmt2) begin
            d.sext     = (as_f == 2'b01) || imm;
            d.srd      = (as_f != 2'b00) && !cg && !imm;
            d.sa_inc   = (as_f == 2'b11) && (src != 4'd0) && (src != 4'd2) && (src != 4'd3);
            d.indirect = as_f[1];
        end else begin
            d.sext     = 1'b0;
        end
        if (fmt1) begin
            d.dext = ad;
            d.drd  = ad && (op != 4'h4);
            d.wb   = ad && (op != 4'h9) && (op != 4'hB);
            d.rw   = !ad && (op != 4'h9) && (op != 4'hB);
        end else if (fmt2) begin
            d.wb   = single_wr && (as_f != 2'b00) && !cg;
            d.rw   = single_wr && (as_f == 2'b00);
        end else begin
            d.wb   = 1'b0;
        end
        return d;
    endfunction

    function automatic state_t first_from(input state_t start, input dec_t d);
        state_t s;
        if ((start <= ST_SEXT) && d.sext) begin
            s = ST_SEXT;
        end else if ((start <= ST_DEXT) && d.dext) begin
            s = ST_DEXT;
        end else if ((start <= ST_SRD) && d.srd) begin
            s = ST_SRD;
        end else if ((start <= ST_DRD) && d.drd) begin
            s = ST_DRD;
        end else begin
            s = ST_EXEC;
        end
        return s;
    endfunction

    // In FETCH the word is still on the bus; afterwards the latched IR drives decode
    assign dec_s = decode((state_q == ST_FETCH) ? MDB_out : ir_q);

    // State and instruction/extension registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RST;
            ir_q      <= 16'h0000;
            ext_src_q <= 16'h0000;
            ext_dst_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            ext_src_q <= ext_src_d;
            ext_dst_q <= ext_dst_d;
        end
    end

    // Next-state and register-load logic
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        ext_src_d = ext_src_q;
        ext_dst_d = ext_dst_q;
        case (state_q)
            ST_RST:   state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_d    = MDB_out;
                    state_d = first_from(ST_SEXT, dec_s);
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_SEXT: begin
                if (mem_ready) begin
                    ext_src_d = MDB_out;
                    state_d   = first_from(ST_DEXT, dec_s);
                end else begin
                    state_d   = ST_SEXT;
                end
            end
            ST_DEXT: begin
                if (mem_ready) begin
                    ext_dst_d = MDB_out;
                    state_d   = first_from(ST_SRD, dec_s);
                end else begin
                    state_d   = ST_DEXT;
                end
            end
            ST_SRD:   state_d = mem_ready ? first_from(ST_DRD, dec_s) : ST_SRD;
            ST_DRD:   state_d = mem_ready ? ST_EXEC : ST_DRD;
            ST_EXEC:  state_d = dec_s.wb ? ST_WB : ST_FETCH;
            ST_WB:    state_d = mem_ready ? ST_FETCH : ST_WB;
            default:  state_d = ST_RST;
        endcase
    end

    // Moore output decode; only mem_ready/cond_true qualify the single-cycle strobes
    always_comb begin
        MAB_sel    = 3'd0;
        MPC        = 3'd0;
        SA_inc     = 1'b0;
        exec       = 1'b0;
        RW         = 1'b0;
        MW         = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            ST_FETCH, ST_SEXT, ST_DEXT: MPC = mem_ready ? 3'd1 : 3'd0;
            ST_SRD: begin
                MAB_sel = dec_s.indirect ? 3'd1 : 3'd2;
                SA_inc  = dec_s.sa_inc && mem_ready;
            end
            ST_DRD:  MAB_sel = 3'd2;
            ST_EXEC: begin
                exec       = !dec_s.illegal;
                illegal    = dec_s.illegal;
                RW         = dec_s.rw;
                MPC        = (dec_s.jump && cond_true) ? 3'd3 : 3'd0;
                instr_done = !dec_s.wb;
            end
            ST_WB: begin
                MAB_sel    = 3'd2;
                MW         = 1'b1;
                instr_done = mem_ready;
            end
            default: MAB_sel = 3'd0;
        endcase
    end

    assign mem_state_s = (state_q != ST_RST) && (state_q != ST_EXEC);
    assign IR          = ir_q;
    assign EXT_SRC     = ext_src_q;
    assign EXT_DST     = ext_dst_q;
    assign busy        = (state_q != ST_RST);

`ifdef MSP430_SEQ_PERF_EN
    logic [15:0] instr_count_q;
    logic [15:0] stall_count_q;

    // Retire and memory-wait counters, wrapping naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count_q <= 16'h0000;
            stall_count_q <= 16'h0000;
        end else begin
            instr_count_q <= instr_done ? (instr_count_q + 16'd1) : instr_count_q;
            stall_count_q <= (mem_state_s && !mem_ready) ? (stall_count_q + 16'd1) : stall_count_q;
        end
    end

    assign instr_count = instr_count_q;
    assign stall_count = stall_count_q;
`else
    logic unused_perf_s;
    assign unused_perf_s = mem_state_s;
    assign instr_count   = 16'h0000;
    assign stall_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_seq.sv
// Directed table-driven bench for instr_seq: per-cycle stimulus with expected Moore outputs,
// plus a hand-written reset-during-write-back sequence and counter checks.
module tb_instr_seq;

    logic        clk;
    logic        rst_n;
    logic [15:0] MDB_out;
    logic        mem_ready;
    logic        cond_true;
    logic [15:0] IR, EXT_SRC, EXT_DST, instr_count, stall_count;
    logic [2:0]  MAB_sel, MPC;
    logic        SA_inc, exec, RW, MW, instr_done, illegal, busy;

    instr_seq dut (
        .clk(clk), .rst_n(rst_n), .MDB_out(MDB_out), .mem_ready(mem_ready),
        .cond_true(cond_true), .IR(IR), .EXT_SRC(EXT_SRC), .EXT_DST(EXT_DST),
        .MAB_sel(MAB_sel), .MPC(MPC), .SA_inc(SA_inc), .exec(exec), .RW(RW),
        .MW(MW), .instr_done(instr_done), .illegal(illegal), .busy(busy),
        .instr_count(instr_count), .stall_count(stall_count)
    );

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] es;
        logic [15:0] ed;
        logic [2:0]  mab;
        logic [2:0]  mpc;
        logic        sa, ex, rw, mw, dn, il, bz;
    } out_t;

    typedef struct {
        string       tag;
        logic [15:0] mdb;
        logic        mr;
        logic        cd;
        out_t        exp;
    } vec_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t tbl[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string tag, input logic [15:0] mdb, input logic mr, input logic cd,
                                input logic [15:0] ir, input logic [15:0] es, input logic [15:0] ed,
                                input logic [2:0] mab, input logic [2:0] mpc, input logic sa, input logic ex,
                                input logic rw, input logic mw, input logic dn, input logic il, input logic bz);
        vec_t v;
        v.tag = tag; v.mdb = mdb; v.mr = mr; v.cd = cd;
        v.exp = '{ir, es, ed, mab, mpc, sa, ex, rw, mw, dn, il, bz};
        return v;
    endfunction

    task automatic check(input string tag, input out_t exp);
        out_t act;
        act = '{IR, EXT_SRC, EXT_DST, MAB_sel, MPC, SA_inc, exec, RW, MW, instr_done, illegal, busy};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got ir=%h es=%h ed=%h mab/mpc/sa/ex/rw/mw/dn/il/bz=%b_%b_%b%b%b%b%b%b%b required ir=%h es=%h ed=%h ctl=%b_%b_%b%b%b%b%b%b%b",
                     tag, act.ir, act.es, act.ed, act.mab, act.mpc, act.sa, act.ex, act.rw, act.mw, act.dn, act.il, act.bz,
                     exp.ir, exp.es, exp.ed, exp.mab, exp.mpc, exp.sa, exp.ex, exp.rw, exp.mw, exp.dn, exp.il, exp.bz);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after a falling edge, compare, then advance one clock
    task automatic apply(input vec_t v);
        MDB_out   = v.mdb;
        mem_ready = v.mr;
        cond_true = v.cd;
        #1;
        check(v.tag, v.exp);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] exp_ic;
        logic [15:0] exp_sc;
        out_t        rst_exp;
        rst_exp = '0;

        //             tag          mdb       mr    cd    ir        es        ed        mab   mpc   sa ex rw mw dn il bz
        tbl.push_back(mk("rst_st",    16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("mov_f",     16'h4405, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("mov_ex",    16'h0000, 1'b1, 1'b0, 16'h4405, 16'h0000, 16'h0000, 3'd0, 3'd0, 0, 1, 1, 0, 1, 0, 1));
        tbl.push_back(mk("imm_f",     16'h4035, 1'b1, 1'b0, 16'h4405, 16'h0000, 16'h0000, 3'd0, 3'd1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("imm_sext",  16'h1234, 1'b1, 1'b0, 16'h4035, 16'h0000, 16'h0000, 3'd0, 3'd1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("imm_ex",    16'h0000, 1'b1, 1'b0, 16'h4035, 16'h1234, 16'h0000, 3'd0, 3'd0, 0, 1, 1, 0, 1, 0, 1));
        tbl.push_back(mk("add_f",     16'h5495, 1'b1, 1'b0, 16'h4035, 16'h1234, 16'h0000, 3'd0, 3'd1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("add_sext",  16'h0002, 1'b1, 1'b0, 16'h5495, 16'h1234, 16'h0000, 3'd0, 3'd1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("add_dext",  16'h0004, 1'b1, 1'b0, 16'h5495, 16'h0002, 16'h0000, 3'd0, 3'd1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("add_srd",   16'hAAAA, 1'b1, 1'b0, 16'h5495, 16'h0002, 16'h0004, 3'd2, 3'd0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("add_drd",   16'hBBBB, 1'b1, 1'b0, 16'h5495, 16'h0002, 16'h0004, 3'd2, 3'd0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("add_ex",    16'h0000, 1'b1, 1'b0, 16'h5495, 16'h0002, 16'h0004, 3'd0, 3'd0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk("add_wb",    16'h0000, 1'b1, 1'b0, 16'h5495, 16'h0002, 16'h0004, 3'd2, 3'd0, 0, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mk("jne1_f",    16'h2003, 1'b1, 1'b0, 16'h5495, 16'h0002, 16'h0004, 3'd0, 3'd1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("jne1_ex",   16'h0000, 1'b1, 1'b1, 16'h2003, 16'h0002, 16'h0004, 3'd0, 3'd3, 0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk("jne0_f",    16'h2003, 1'b1, 1'b0, 16'h2003, 16'h0002, 16'h0004, 3'd0, 3'd1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("jne0_ex",   16'h0000, 1'b1, 1'b0, 16'h2003, 16'h0002, 16'h0004, 3'd0, 3'd0, 0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk("ill_f",     16'h0123, 1'b1, 1'b0, 16'h2003, 16'h0002, 16'h0004, 3'd0, 3'd1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("ill_ex",    16'h0000, 1'b1, 1'b0, 16'h0123, 16'h0002, 16'h0004, 3'd0, 3'd0, 0, 0, 0, 0, 1, 1, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk($sformatf("stall_%0d", i), 16'h4405, 1'b0, 1'b0, 16'h0123, 16'h0002, 16'h0004, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("stall_go",  16'h4405, 1'b1, 1'b0, 16'h0123, 16'h0002, 16'h0004, 3'd0, 3'd1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("stall_ex",  16'h0000, 1'b1, 1'b0, 16'h4405, 16'h0002, 16'h0004, 3'd0, 3'd0, 0, 1, 1, 0, 1, 0, 1));
        tbl.push_back(mk("ainc_f",    16'h4536, 1'b1, 1'b0, 16'h4405, 16'h0002, 16'h0004, 3'd0, 3'd1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("ainc_srd",  16'hCCCC, 1'b1, 1'b0, 16'h4536, 16'h0002, 16'h0004, 3'd1, 3'd0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("ainc_ex",   16'h0000, 1'b1, 1'b0, 16'h4536, 16'h0002, 16'h0004, 3'd0, 3'd0, 0, 1, 1, 0, 1, 0, 1));

        rst_n     = 1'b0;
        MDB_out   = 16'h0000;
        mem_ready = 1'b0;
        cond_true = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_hold", rst_exp);
        check16("reset_icnt", instr_count, 16'h0000);
        check16("reset_scnt", stall_count, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

`ifdef MSP430_SEQ_PERF_EN
        exp_ic = 16'd8;
        exp_sc = 16'd3;
`else
        exp_ic = 16'd0;
        exp_sc = 16'd0;
`endif
        check16("instr_count", instr_count, exp_ic);
        check16("stall_count", stall_count, exp_sc);

        // Read-modify-write instruction with a stalled write-back, then reset mid-WB
        apply(mk("rb_f",     16'h5495, 1'b1, 1'b0, 16'h4536, 16'h0002, 16'h0004, 3'd0, 3'd1, 0, 0, 0, 0, 0, 0, 1));
        apply(mk("rb_sext",  16'h0010, 1'b1, 1'b0, 16'h5495, 16'h0002, 16'h0004, 3'd0, 3'd1, 0, 0, 0, 0, 0, 0, 1));
        apply(mk("rb_dext",  16'h0020, 1'b1, 1'b0, 16'h5495, 16'h0010, 16'h0004, 3'd0, 3'd1, 0, 0, 0, 0, 0, 0, 1));
        apply(mk("rb_srd",   16'h0000, 1'b1, 1'b0, 16'h5495, 16'h0010, 16'h0020, 3'd2, 3'd0, 0, 0, 0, 0, 0, 0, 1));
        apply(mk("rb_drd",   16'h0000, 1'b1, 1'b0, 16'h5495, 16'h0010, 16'h0020, 3'd2, 3'd0, 0, 0, 0, 0, 0, 0, 1));
        apply(mk("rb_ex",    16'h0000, 1'b1, 1'b0, 16'h5495, 16'h0010, 16'h0020, 3'd0, 3'd0, 0, 1, 0, 0, 0, 0, 1));
        apply(mk("rb_wb0",   16'h0000, 1'b0, 1'b0, 16'h5495, 16'h0010, 16'h0020, 3'd2, 3'd0, 0, 0, 0, 1, 0, 0, 1));
        apply(mk("rb_wb1",   16'h0000, 1'b0, 1'b0, 16'h5495, 16'h0010, 16'h0020, 3'd2, 3'd0, 0, 0, 0, 1, 0, 0, 1));
        rst_n = 1'b0;
        #1;
        check("rb_async", rst_exp);
        check16("rb_icnt", instr_count, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk("rb_rst",   16'h4405, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk("rb_refetch", 16'h4405, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd1, 0, 0, 0, 0, 0, 0, 1));
        apply(mk("rb_reexec",  16'h0000, 1'b1, 1'b0, 16'h4405, 16'h0000, 16'h0000, 3'd0, 3'd0, 0, 1, 1, 0, 1, 0, 1));

`ifdef MSP430_SEQ_PERF_EN
        exp_ic = 16'd1;
`else
        exp_ic = 16'd0;
`endif
        check16("post_rst_icnt", instr_count, exp_ic);
        check16("post_rst_scnt", stall_count, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
